line_wr_ctrl: RTL and testbench

Write-side controller for the horizontal-scaler line buffer. It takes the incoming raster pixel stream and produces the write port (`wr_addr`/`wr_data`/`wr_en`) of the scaler line RAM. The RAM is used as two ping-pong line banks. A `line_rdy`/`line_ack` handshake tells the scaler read side which bank holds a complete line and when that bank may be refilled.

---
 rtl/line_wr_ctrl.sv | 138 +++++++++++++
 tb/tb_line_wr_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_wr_ctrl.sv
// line_wr_ctrl: ping-pong line-bank write controller for the horizontal-scaler line RAM.
// Define LINE_WR_YSKIP_EN for 2:1 vertical decimation (only even raw lines are captured).
module line_wr_ctrl #(
  parameter int H_LEN    = 11,
  parameter int ADDR_LEN = 11,
  parameter int DATA_LEN = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_vsync,
  input  logic                in_de,
  input  logic [DATA_LEN-1:0] in_data,
  input  logic [H_LEN-1:0]    h_active,
  input  logic                line_ack,
  output logic [ADDR_LEN-1:0] wr_addr,
  output logic [DATA_LEN-1:0] wr_data,
  output logic                wr_en,
  output logic                wr_bank,
  output logic                line_rdy,
  output logic                line_bank,
  output logic [H_LEN-1:0]    line_len,
  output logic [11:0]         line_cnt,
  output logic                ovf
);
  localparam logic [1:0] IDLE = 2'd0, WAIT_LINE = 2'd1, CAPTURE = 2'd2, DROP = 2'd3;
  logic [1:0] state_q, state_d, full_q, full_d, full_a;
  logic de_q, last_q, last_d, order_q, order_d, ovf_q, ovf_d;
  logic [H_LEN-1:0] pix_q, pix_d, len0_q, len0_d, len1_q, len1_d, llen_q;
  logic [11:0] cnt_q, cnt_d;
  logic rise, beat, skip, ack, we, cmp, tgt;
  logic wr_en_q, wr_bank_q, rdy_q, lbank_q;
  logic [ADDR_LEN-1:0] wr_addr_q;
  logic [DATA_LEN-1:0] wr_data_q;
  assign tgt    = ~last_q;
  assign rise   = in_de & ~de_q;
  assign beat   = in_de & (pix_q < h_active);
  assign ack    = line_ack & |full_q;
  assign full_a = full_q & ~({order_q, ~order_q} & {2{ack}});
`ifdef LINE_WR_YSKIP_EN
  logic raw_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) raw_q <= 1'b0;
    else if (in_vsync) raw_q <= 1'b0;
    else if (state_q == WAIT_LINE && rise) raw_q <= ~raw_q;
  end
  assign skip = raw_q;
`else
  assign skip = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    cmp     = 1'b0;
    if (in_vsync) begin
      state_d = WAIT_LINE;
      pix_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else case (state_q)
      WAIT_LINE: if (rise) begin
        state_d = (skip || full_q[tgt]) ? DROP : CAPTURE;
        ovf_d   = ovf_q | (~skip & full_q[tgt]);
        we      = ~skip & ~full_q[tgt] & beat;
        pix_d   = pix_q + H_LEN'(we);
      end
      CAPTURE: begin
        cmp     = ~in_de;
        we      = beat;
        state_d = in_de ? CAPTURE : WAIT_LINE;
        last_d  = last_q ^ cmp;
        pix_d   = cmp ? '0 : pix_q + H_LEN'(we);
        cnt_d   = (cmp && cnt_q != 12'hFFF) ? cnt_q + 12'd1 : cnt_q;
      end
      DROP: state_d = in_de ? DROP : WAIT_LINE;
      default: ;
    endcase
  end
  assign len0_d  = (cmp & ~tgt) ? pix_q : len0_q;
  assign len1_d  = (cmp & tgt) ? pix_q : len1_q;
  assign full_d  = in_vsync ? 2'b00 : full_a | ({tgt, ~tgt} & {2{cmp}});
  // With both banks full after a completion, the other bank is the older one.
  assign order_d = (full_d == 2'b01) ? 1'b0 : (full_d == 2'b10) ? 1'b1 :
                   (full_d == 2'b11 && cmp) ? ~tgt : order_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      de_q      <= 1'b0;
      last_q    <= 1'b1;
      full_q    <= 2'b00;
      order_q   <= 1'b0;
      ovf_q     <= 1'b0;
      pix_q     <= '0;
      len0_q    <= '0;
      len1_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_bank_q <= 1'b0;
      rdy_q     <= 1'b0;
      lbank_q   <= 1'b0;
      llen_q    <= '0;
    end else begin
      state_q <= state_d;
      de_q    <= in_de;
      last_q  <= last_d;
      full_q  <= full_d;
      order_q <= order_d;
      ovf_q   <= ovf_d;
      pix_q   <= pix_d;
      len0_q  <= len0_d;
      len1_q  <= len1_d;
      cnt_q   <= cnt_d;
      wr_en_q <= we;
      if (we) begin
        wr_addr_q <= ADDR_LEN'(pix_q);
        wr_data_q <= in_data;
        wr_bank_q <= tgt;
      end
      rdy_q   <= |full_d;
      lbank_q <= order_d;
      llen_q  <= order_d ? len1_d : len0_d;
    end
  end
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_bank   = wr_bank_q;
  assign line_rdy  = rdy_q;
  assign line_bank = lbank_q;
  assign line_len  = llen_q;
  assign line_cnt  = cnt_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_line_wr_ctrl.sv
// tb_line_wr_ctrl: scoreboard bench for line_wr_ctrl; RAM writes are checked against a queue of expected writes.
module tb_line_wr_ctrl;
  logic clk = 1'b0, rst = 1'b1, in_vsync = 1'b0, in_de = 1'b0, line_ack = 1'b0;
  logic [15:0] in_data = '0;
  logic [10:0] h_active = 11'd8;
  logic [10:0] wr_addr, line_len;
  logic [15:0] wr_data;
  logic wr_en, wr_bank, line_rdy, line_bank, ovf;
  logic [11:0] line_cnt;
  logic [27:0] sb[$];
  logic [27:0] exp_w;
  int pass_cnt = 0, tot_cnt = 0;

  always #5 clk = ~clk;

  line_wr_ctrl dut (
    .clk(clk), .rst(rst), .in_vsync(in_vsync), .in_de(in_de), .in_data(in_data),
    .h_active(h_active), .line_ack(line_ack), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .wr_bank(wr_bank), .line_rdy(line_rdy), .line_bank(line_bank),
    .line_len(line_len), .line_cnt(line_cnt), .ovf(ovf)
  );

  always @(negedge clk) begin
    if (!rst && wr_en) begin
      tot_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL wr_unexpected got bank=%0d addr=%0d data=%h, expected no write", wr_bank, wr_addr, wr_data);
      end else begin
        exp_w = sb.pop_front();
        if ({wr_bank, wr_addr, wr_data} !== exp_w)
          $display("FAIL wr_port got bank=%0d addr=%0d data=%h, expected bank=%0d addr=%0d data=%h",
                   wr_bank, wr_addr, wr_data, exp_w[27], exp_w[26:16], exp_w[15:0]);
        else pass_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_vsync();
    in_vsync = 1'b1;
    step();
    in_vsync = 1'b0;
  endtask

  task automatic pulse_ack();
    line_ack = 1'b1;
    step();
    line_ack = 1'b0;
  endtask

  task automatic send_line(input int n, input logic [15:0] base, input int nwr, input logic bank, input logic ack_end);
    for (int i = 0; i < n; i++) begin
      in_de = 1'b1;
      in_data = base + 16'(i);
      if (i < nwr) sb.push_back({bank, 11'(i), base + 16'(i)});
      step();
    end
    in_de = 1'b0;
    line_ack = ack_end;
    step();
    line_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tot_cnt++;
    if ({wr_en, wr_addr, wr_data, wr_bank, line_rdy, line_bank, line_len, line_cnt, ovf} !== 55'd0)
      $display("FAIL reset_outputs got %h, expected 0",
               {wr_en, wr_addr, wr_data, wr_bank, line_rdy, line_bank, line_len, line_cnt, ovf});
    else pass_cnt++;
    rst = 1'b0;
    step();
    in_de = 1'b1;
    repeat (3) step();
    in_de = 1'b0;
    step();
    tot_cnt++;
    if ({line_rdy, line_cnt} !== 13'd0) $display("FAIL idle_ignore got rdy=%0d cnt=%0d, expected 0/0", line_rdy, line_cnt);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    pulse_vsync();
    for (int i = 0; i < 8; i++) begin
      in_de = 1'b1;
      in_data = 16'h0100 + 16'(i);
      sb.push_back({1'b0, 11'(i), 16'h0100 + 16'(i)});
      step();
    end
    tot_cnt++;
    if (line_rdy !== 1'b0) $display("FAIL basic_early_rdy got %0d, expected 0", line_rdy);
    else pass_cnt++;
    in_de = 1'b0;
    step();
    tot_cnt++;
    if ({line_rdy, line_bank, line_len, line_cnt} !== {1'b1, 1'b0, 11'd8, 12'd1})
      $display("FAIL basic_line got rdy=%0d bank=%0d len=%0d cnt=%0d, expected 1/0/8/1", line_rdy, line_bank, line_len, line_cnt);
    else pass_cnt++;
    tot_cnt++;
    if (sb.size() !== 0) $display("FAIL basic_writes got %0d pending, expected 0", sb.size());
    else pass_cnt++;
    pulse_ack();
    tot_cnt++;
    if (line_rdy !== 1'b0) $display("FAIL basic_ack got rdy=%0d, expected 0", line_rdy);
    else pass_cnt++;
  endtask

  task automatic test_truncate();
    pulse_vsync();
    h_active = 11'd10;
    send_line(12, 16'h0200, 10, 1'b1, 1'b0);
    tot_cnt++;
    if ({line_rdy, line_bank, line_len, line_cnt} !== {1'b1, 1'b1, 11'd10, 12'd1})
      $display("FAIL trunc_line got rdy=%0d bank=%0d len=%0d cnt=%0d, expected 1/1/10/1", line_rdy, line_bank, line_len, line_cnt);
    else pass_cnt++;
    tot_cnt++;
    if (sb.size() !== 0) $display("FAIL trunc_writes got %0d pending, expected 0", sb.size());
    else pass_cnt++;
    pulse_ack();
  endtask

  task automatic test_ack_complete();
    pulse_vsync();
    h_active = 11'd8;
    send_line(3, 16'h0300, 3, 1'b0, 1'b0);
    send_line(4, 16'h0310, 4, 1'b1, 1'b1);
    tot_cnt++;
    if ({line_rdy, line_bank, line_len, line_cnt} !== {1'b1, 1'b1, 11'd4, 12'd2})
      $display("FAIL ackcmp_line got rdy=%0d bank=%0d len=%0d cnt=%0d, expected 1/1/4/2", line_rdy, line_bank, line_len, line_cnt);
    else pass_cnt++;
    pulse_ack();
    tot_cnt++;
    if (line_rdy !== 1'b0) $display("FAIL ackcmp_drain got rdy=%0d, expected 0", line_rdy);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    pulse_vsync();
    send_line(5, 16'h0400, 5, 1'b0, 1'b0);
    send_line(7, 16'h0410, 7, 1'b1, 1'b0);
    send_line(4, 16'h0420, 0, 1'b0, 1'b0);
    tot_cnt++;
    if ({line_rdy, line_bank, line_len, line_cnt, ovf} !== {1'b1, 1'b0, 11'd5, 12'd2, 1'b1})
      $display("FAIL ovf_state got rdy=%0d bank=%0d len=%0d cnt=%0d ovf=%0d, expected 1/0/5/2/1",
               line_rdy, line_bank, line_len, line_cnt, ovf);
    else pass_cnt++;
    pulse_ack();
    tot_cnt++;
    if ({line_rdy, line_bank, line_len} !== {1'b1, 1'b1, 11'd7})
      $display("FAIL ovf_ack1 got rdy=%0d bank=%0d len=%0d, expected 1/1/7", line_rdy, line_bank, line_len);
    else pass_cnt++;
    pulse_ack();
    pulse_ack();
    tot_cnt++;
    if ({line_rdy, ovf} !== 2'b01) $display("FAIL ovf_ack2 got rdy=%0d ovf=%0d, expected 0/1", line_rdy, ovf);
    else pass_cnt++;
  endtask

  task automatic test_vsync_abort();
    for (int i = 0; i < 5; i++) begin
      in_de = 1'b1;
      in_data = 16'h0500 + 16'(i);
      sb.push_back({1'b0, 11'(i), 16'h0500 + 16'(i)});
      step();
    end
    in_data = 16'h05FF;
    in_vsync = 1'b1;
    step();
    in_vsync = 1'b0;
    in_de = 1'b0;
    step();
    tot_cnt++;
    if ({line_rdy, line_cnt, ovf} !== 14'd0)
      $display("FAIL vs_abort got rdy=%0d cnt=%0d ovf=%0d, expected 0/0/0", line_rdy, line_cnt, ovf);
    else pass_cnt++;
    send_line(3, 16'h0600, 3, 1'b0, 1'b0);
    tot_cnt++;
    if ({line_rdy, line_bank, line_len, line_cnt} !== {1'b1, 1'b0, 11'd3, 12'd1})
      $display("FAIL vs_next got rdy=%0d bank=%0d len=%0d cnt=%0d, expected 1/0/3/1", line_rdy, line_bank, line_len, line_cnt);
    else pass_cnt++;
    tot_cnt++;
    if (sb.size() !== 0) $display("FAIL vs_writes got %0d pending, expected 0", sb.size());
    else pass_cnt++;
    pulse_ack();
  endtask

  task automatic test_zero_hactive();
    h_active = 11'd0;
    send_line(3, 16'h0700, 0, 1'b1, 1'b0);
    tot_cnt++;
    if ({line_rdy, line_bank, line_len, line_cnt} !== {1'b1, 1'b1, 11'd0, 12'd2})
      $display("FAIL zero_len got rdy=%0d bank=%0d len=%0d cnt=%0d, expected 1/1/0/2", line_rdy, line_bank, line_len, line_cnt);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    pulse_vsync();
    for (int i = 0; i < 4100; i++) send_line(1, 16'h0, 0, 1'b0, 1'b1);
    tot_cnt++;
    if ({line_rdy, line_cnt, ovf} !== {1'b1, 12'hFFF, 1'b0})
      $display("FAIL saturate got rdy=%0d cnt=%0d ovf=%0d, expected 1/4095/0", line_rdy, line_cnt, ovf);
    else pass_cnt++;
  endtask

  task automatic test_yskip();
    pulse_vsync();
    h_active = 11'd8;
    send_line(3, 16'h0800, 3, 1'b0, 1'b0);
    send_line(3, 16'h0810, 0, 1'b0, 1'b0);
    send_line(3, 16'h0820, 3, 1'b1, 1'b0);
    send_line(3, 16'h0830, 0, 1'b0, 1'b0);
    tot_cnt++;
    if ({line_rdy, line_bank, line_len, line_cnt, ovf} !== {1'b1, 1'b0, 11'd3, 12'd2, 1'b0})
      $display("FAIL yskip got rdy=%0d bank=%0d len=%0d cnt=%0d ovf=%0d, expected 1/0/3/2/0",
               line_rdy, line_bank, line_len, line_cnt, ovf);
    else pass_cnt++;
    tot_cnt++;
    if (sb.size() !== 0) $display("FAIL yskip_writes got %0d pending, expected 0", sb.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
`ifdef LINE_WR_YSKIP_EN
    test_yskip();
`else
    test_basic();
    test_truncate();
    test_ack_complete();
    test_overflow();
    test_vsync_abort();
    test_zero_hactive();
    test_saturate();
`endif
    step();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
